spi_frame_parser: RTL and testbench
===================================

SPI_FRAME_PARSER -- requirements
Module: spi_frame_parser

Interface
REQ-001 SHALL have parameter HEADER, default 7'h23, the expected 7-bit header value in byte 0 bits [6:0].
REQ-002 SHALL have parameter MAX_LEN, default 64, the maximum number of payload bytes per frame, from 1 to 255.
REQ-003 SHALL have ports, in order:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_tvalid  in  1  raw byte valid, from the SPI target.
- s_tready  out  1  raw byte accept.
- s_tdata  in  8  raw byte.
- frame_end_i  in  1  one-cycle pulse, SSEL deasserted (already synchronised to clock).
- m_tvalid  out  1  framed payload valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  last payload byte of the frame.
- m_tuser  out  1  command bit (header bit 7), constant for the whole frame.
- m_tdata  out  8  payload byte.
- hdr_err_o  out  1  one-cycle pulse, header mismatch.
- len_err_o  out  1  one-cycle pulse, payload exceeded MAX_LEN.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-004 SHALL use an FSM with states IDLE, DATA, DROP and FLUSH.
REQ-005 IDLE: the first accepted byte is the header.
- If bits [6:0] equal HEADER: latch bit 7 into the cmd register, clear the length counter, go to DATA.
- Otherwise: pulse hdr_err_o the following cycle and go to DROP.
REQ-006 DATA: each accepted byte goes into a one-byte hold register and the length counter increments.
- If the hold register is occupied, its previous byte SHALL be presented on m_* with m_tlast=0 in the cycle after the new byte is accepted.
REQ-007 On end-of-frame in DATA with the hold register occupied: present the held byte with m_tlast=1, then go to FLUSH.
REQ-008 On end-of-frame in DATA with the hold register empty (header-only frame): emit no output and return to IDLE.
REQ-009 Byte number MAX_LEN+1 in DATA SHALL be discarded.
- Pulse len_err_o.
- Present the held byte with m_tlast=1.
- Go to DROP.
REQ-010 DROP: accept and discard bytes (s_tready=1) until end-of-frame, then go to IDLE.
REQ-011 FLUSH: s_tready=0; go to IDLE once m_tvalid&&m_tready.
REQ-012 frame_end_i SHALL be latched into a pending flag whenever it cannot be acted on immediately. The flag is consumed when the FSM processes end-of-frame.
- frame_end_i in IDLE with no pending frame is ignored.
REQ-013 If s_tvalid&&s_tready and frame_end_i occur in the same cycle, the byte SHALL belong to the ending frame and be processed before end-of-frame.
REQ-014 s_tready SHALL be low in DATA while the output register holds an unaccepted byte and the hold register is occupied. No byte is ever dropped in DATA.
REQ-015 m_tdata, m_tlast and m_tuser SHALL stay stable while m_tvalid && !m_tready.
REQ-016 Minimum latency is 1 cycle, from the accepting handshake (or end-of-frame) to m_tvalid. Sustained throughput is 1 byte/cycle with m_tready=1.
REQ-017 The length counter SHALL be 8 bits and saturate. It SHALL never wrap.

Reset
REQ-018 While reset is high, asynchronously:
- state=IDLE
- m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0
- s_tready=0
- hdr_err_o=0, len_err_o=0, busy_o=0
- hold register empty, pending-end flag clear.
REQ-019 s_tready SHALL go to 1 in the first cycle after reset is released.
REQ-020 Reset mid-frame SHALL discard any partial frame. The next accepted byte is treated as a header.

Configuration
REQ-021 Macro SPI_FRAME_STATS_EN.
- When defined: add outputs frames_o[15:0], hdr_errs_o[7:0] and len_errs_o[7:0] as saturating counters, all cleared by reset. frames_o increments on every m_tlast handshake; the other two increment on their error pulses.
- When undefined: these ports and counters do not exist, and all other behaviour is identical.

Structure
REQ-022 FSM state encoding and the header/command bit-field positions SHALL live in shared package spi_frame_pkg.
REQ-023 The output register with hold SHALL be a sub-module, axis_skid (8-bit data, tlast, tuser), instantiated once.

Verification
REQ-024 Input 0xA3,0x11,0x22,0x33, then frame_end_i -> output 0x11,0x22,0x33; m_tlast only on 0x33; m_tuser=1 on all three.
REQ-025 Input 0x55,0x01,0x02, then frame_end_i -> no m_tvalid; hdr_err_o pulses once; then 0x23,0x7E, end -> single byte 0x7E, m_tlast=1, m_tuser=0.
REQ-026 MAX_LEN=4, input 0x23 then 6 payload bytes 0x00..0x05, then end -> output 0x00..0x03 with m_tlast on 0x03; len_err_o pulses once; busy_o falls after end.
REQ-027 m_tready toggling 1/0 every cycle during REQ-024 stimulus -> identical byte sequence; no loss; outputs stable while stalled.
REQ-028 frame_end_i in the same cycle as the handshake of the last byte 0x33 (REQ-024 stimulus) -> 0x33 carries m_tlast=1; header-only frame 0x23, end -> no output, busy_o low after 2 cycles.
REQ-029 Reset asserted after 0x23,0x11 -> all outputs zero immediately; after release, 0x23,0x44, end -> single byte 0x44 with m_tlast=1.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// spi_frame_parser shared types: FSM state encoding, header/command
// bit positions and a saturating 8-bit increment helper.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DROP  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int HDR_MSB = 6;
  localparam int HDR_LSB = 0;
  localparam int CMD_BIT = 7;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axis_skid.sv
// axis_skid: output register plus one skid entry so i/o_ready is registered.
// Ports: clock/reset, i_valid/o_ready/i_data/i_last/i_user in, m_* AXIS out.
module axis_skid (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_user,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic       m_tlast,
  output logic       m_tuser
);

  logic       r_out_v;
  logic       r_sk_v;
  logic [9:0] r_out;
  logic [9:0] r_sk;
  logic       w_free;
  logic       w_push;

  assign w_free  = !r_out_v || m_tready;
  assign w_push  = i_valid && !r_sk_v;
  assign o_ready = !r_sk_v;

  // Output register only changes when empty or being taken,
  // so m_* stays stable under backpressure.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_v <= 1'b0;
      r_sk_v  <= 1'b0;
      r_out   <= '0;
      r_sk    <= '0;
    end else if (w_free) begin
      if (r_sk_v) begin
        r_out   <= r_sk;
        r_out_v <= 1'b1;
        r_sk_v  <= 1'b0;
      end else if (w_push) begin
        r_out   <= {i_user, i_last, i_data};
        r_out_v <= 1'b1;
      end else begin
        r_out_v <= 1'b0;
      end
    end else if (w_push) begin
      r_sk   <= {i_user, i_last, i_data};
      r_sk_v <= 1'b1;
    end
  end

  assign m_tvalid = r_out_v;
  assign {m_tuser, m_tlast, m_tdata} = r_out;

endmodule

// File: rtl/spi_frame_parser.sv
// spi_frame_parser: header check, 1-byte lookahead to mark tlast, length
// limit, AXIS out via axis_skid. Ports: clock/reset, s_* raw bytes,
// frame_end_i, m_* payload, hdr_err_o/len_err_o pulses, busy_o.
// Optional SPI_FRAME_STATS_EN adds frames_o/hdr_errs_o/len_errs_o counters.
module spi_frame_parser
  import spi_frame_pkg::*;
#(
  parameter logic [6:0] HEADER  = 7'h23,
  parameter int         MAX_LEN = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [7:0]  s_tdata,
  input  logic        frame_end_i,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [7:0]  m_tdata,
  output logic        hdr_err_o,
  output logic        len_err_o,
  output logic        busy_o
`ifdef SPI_FRAME_STATS_EN
  ,
  output logic [15:0] frames_o,
  output logic [7:0]  hdr_errs_o,
  output logic [7:0]  len_errs_o
`endif
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_alive;
  logic       r_pend;
  logic       r_hold_v;
  logic [7:0] r_hold;
  logic       r_cmd;
  logic [7:0] r_len;
  logic       r_hdr_err;
  logic       r_len_err;

  logic w_acc;
  logic w_end;
  logic w_rdy;
  logic w_sk_rdy;
  logic w_hdr_ok;
  logic w_over;
  logic w_push;
  logic w_push_last;
  logic w_hold_ld;
  logic w_hold_clr;
  logic w_len_clr;
  logic w_len_inc;
  logic w_pend_nxt;
  logic w_hdr_err;
  logic w_len_err;
  logic w_cmd_ld;

  assign s_tready = r_alive && w_rdy;
  assign w_acc    = s_tvalid && s_tready;
  assign w_end    = frame_end_i || r_pend;
  assign w_hdr_ok = s_tdata[HDR_MSB:HDR_LSB] == HEADER;
  assign w_over   = r_len == 8'(MAX_LEN);
  assign busy_o   = r_state != ST_IDLE;
  assign hdr_err_o = r_hdr_err;
  assign len_err_o = r_len_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_hold_ld   = 1'b0;
    w_hold_clr  = 1'b0;
    w_len_clr   = 1'b0;
    w_len_inc   = 1'b0;
    w_pend_nxt  = r_pend;
    w_hdr_err   = 1'b0;
    w_len_err   = 1'b0;
    w_cmd_ld    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_rdy      = 1'b1;
        w_pend_nxt = 1'b0;
        if (w_acc) begin
          // header and end together: end handled from DATA/DROP
          w_pend_nxt = frame_end_i;
          if (w_hdr_ok) begin
            w_cmd_ld    = 1'b1;
            w_len_clr   = 1'b1;
            w_hold_clr  = 1'b1;
            w_state_nxt = ST_DATA;
          end else begin
            w_hdr_err   = 1'b1;
            w_state_nxt = ST_DROP;
          end
        end
      end
      ST_DATA: begin
        w_rdy = !r_pend && (!r_hold_v || w_sk_rdy);
        if (w_acc) begin
          if (frame_end_i) w_pend_nxt = 1'b1;
          if (w_over) begin
            w_len_err   = 1'b1;
            w_push      = 1'b1;
            w_push_last = 1'b1;
            w_hold_clr  = 1'b1;
            w_state_nxt = ST_DROP;
          end else begin
            w_push    = r_hold_v;
            w_hold_ld = 1'b1;
            w_len_inc = 1'b1;
          end
        end else if (w_end) begin
          if (!r_hold_v) begin
            w_pend_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end else if (w_sk_rdy) begin
            w_push      = 1'b1;
            w_push_last = 1'b1;
            w_hold_clr  = 1'b1;
            w_pend_nxt  = 1'b0;
            w_state_nxt = ST_FLUSH;
          end else begin
            w_pend_nxt = 1'b1;
          end
        end
      end
      ST_DROP: begin
        w_rdy = !r_pend;
        if (w_end) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_pend_nxt = 1'b0;
        if (m_tvalid && m_tready && m_tlast)
          w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alive   <= 1'b0;
      r_pend    <= 1'b0;
      r_hold_v  <= 1'b0;
      r_hold    <= '0;
      r_cmd     <= 1'b0;
      r_len     <= '0;
      r_hdr_err <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_alive   <= 1'b1;
      r_pend    <= w_pend_nxt;
      r_hdr_err <= w_hdr_err;
      r_len_err <= w_len_err;
      if (w_cmd_ld) r_cmd <= s_tdata[CMD_BIT];
      if (w_hold_ld) begin
        r_hold   <= s_tdata;
        r_hold_v <= 1'b1;
      end else if (w_hold_clr) begin
        r_hold_v <= 1'b0;
      end
      if (w_len_clr)      r_len <= '0;
      else if (w_len_inc) r_len <= sat_inc8(r_len);
    end
  end

  axis_skid u_skid (
    .clock    (clock),
    .reset    (reset),
    .i_valid  (w_push),
    .o_ready  (w_sk_rdy),
    .i_data   (r_hold),
    .i_last   (w_push_last),
    .i_user   (r_cmd),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser)
  );

`ifdef SPI_FRAME_STATS_EN
  logic [15:0] r_frames;
  logic [7:0]  r_hdr_errs;
  logic [7:0]  r_len_errs;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frames   <= '0;
      r_hdr_errs <= '0;
      r_len_errs <= '0;
    end else begin
      if (m_tvalid && m_tready && m_tlast && r_frames != 16'hFFFF)
        r_frames <= r_frames + 16'd1;
      if (r_hdr_err) r_hdr_errs <= sat_inc8(r_hdr_errs);
      if (r_len_err) r_len_errs <= sat_inc8(r_len_errs);
    end
  end

  assign frames_o   = r_frames;
  assign hdr_errs_o = r_hdr_errs;
  assign len_errs_o = r_len_errs;
`endif

endmodule

// File: tb/tb_spi_frame_parser.sv
// Self-checking bench for spi_frame_parser (MAX_LEN=4) with an output
// scoreboard; each scenario task drives bytes and checks inline.
module tb_spi_frame_parser;

  logic       clock = 1'b0;
  logic       reset;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] s_tdata;
  logic       frame_end_i;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       m_tuser;
  logic [7:0] m_tdata;
  logic       hdr_err_o;
  logic       len_err_o;
  logic       busy_o;
`ifdef SPI_FRAME_STATS_EN
  logic [15:0] frames_o;
  logic [7:0]  hdr_errs_o;
  logic [7:0]  len_errs_o;
`endif

  always #5 clock = ~clock;

  spi_frame_parser #(.HEADER(7'h23), .MAX_LEN(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .frame_end_i (frame_end_i),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .m_tdata     (m_tdata),
    .hdr_err_o   (hdr_err_o),
    .len_err_o   (len_err_o),
    .busy_o      (busy_o)
`ifdef SPI_FRAME_STATS_EN
    ,
    .frames_o    (frames_o),
    .hdr_errs_o  (hdr_errs_o),
    .len_errs_o  (len_errs_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  int hdr_cnt = 0;
  int len_cnt = 0;
  int cyc = 0;
  logic [9:0] exp_q[$];
  logic       tog_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    if (tog_en) m_tready = ~m_tready;
  end

  // scoreboard and stability monitor
  always @(negedge clock) begin
    logic [9:0] got;
    logic [9:0] exp;
    got = {m_tuser, m_tlast, m_tdata};
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || got !== prev_out) begin
          errors++;
          $display("FAIL stall_stable: got v=%b %h, required v=1 %h",
                   m_tvalid, got, prev_out);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = got;
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h, required none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL out_byte: got user/last/data %h, required %h",
                     got, exp);
          end
        end
      end
      if (hdr_err_o) hdr_cnt++;
      if (len_err_o) len_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic fe);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = b;
    @(negedge clock);
    while (!s_tready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_tready=%b byte %h, required 1", s_tready, b);
    end
    frame_end_i = fe;
    @(posedge clock);
    #1;
    s_tvalid    = 1'b0;
    frame_end_i = 1'b0;
  endtask

  task automatic end_frame();
    frame_end_i = 1'b1;
    @(posedge clock);
    #1;
    frame_end_i = 1'b0;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    frame_end_i = 1'b0;
    m_tready = 1'b1;
    #12;
    checks++;
    if ({m_tvalid, m_tlast, m_tuser, m_tdata, s_tready} !== 12'h0) begin
      errors++;
      $display("FAIL reset_out: got v%b l%b u%b d%h r%b, required all 0",
               m_tvalid, m_tlast, m_tuser, m_tdata, s_tready);
    end
    checks++;
    if ({hdr_err_o, len_err_o, busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000",
               {hdr_err_o, len_err_o, busy_o});
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", s_tready);
    end
  endtask

  task automatic test_basic();
    int n;
    int h0 = hdr_cnt;
    exp_q.push_back({1'b1, 1'b0, 8'h11});
    exp_q.push_back({1'b1, 1'b0, 8'h22});
    exp_q.push_back({1'b1, 1'b1, 8'h33});
    send_byte(8'hA3, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h11) begin
      errors++;
      $display("FAIL latency: got v%b %h, required v1 11", m_tvalid, m_tdata);
    end
    send_byte(8'h33, 1'b0);
    end_frame();
    wait_drain(n);
    checks++;
    if (n >= 200 || hdr_cnt != h0) begin
      errors++;
      $display("FAIL basic_drain: got left=%0d hdr=%0d, required 0 %0d",
               exp_q.size(), hdr_cnt, h0);
    end
  endtask

  task automatic test_hdr_err();
    int n;
    int h0 = hdr_cnt;
    send_byte(8'h55, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    end_frame();
    wait_drain(n);
    checks++;
    if (hdr_cnt != h0 + 1 || n >= 200) begin
      errors++;
      $display("FAIL hdr_err_pulse: got %0d, required %0d", hdr_cnt - h0, 1);
    end
    exp_q.push_back({1'b0, 1'b1, 8'h7E});
    send_byte(8'h23, 1'b0);
    send_byte(8'h7E, 1'b0);
    end_frame();
    wait_drain(n);
    checks++;
    if (n >= 200 || hdr_cnt != h0 + 1) begin
      errors++;
      $display("FAIL hdr_recover: got left=%0d hdr=%0d, required 0 %0d",
               exp_q.size(), hdr_cnt - h0, 1);
    end
  endtask

  task automatic test_len_err();
    int n;
    int l0 = len_cnt;
    for (int i = 0; i < 4; i++)
      exp_q.push_back({1'b0, (i == 3), 8'(i)});
    send_byte(8'h23, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'(i), 1'b0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL len_busy: got %b, required 1", busy_o);
    end
    end_frame();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL len_busy_fall: got %b, required 0", busy_o);
    end
    wait_drain(n);
    checks++;
    if (len_cnt != l0 + 1 || n >= 200) begin
      errors++;
      $display("FAIL len_err_pulse: got %0d left=%0d, required 1 0",
               len_cnt - l0, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int n;
    exp_q.push_back({1'b1, 1'b0, 8'h11});
    exp_q.push_back({1'b1, 1'b0, 8'h22});
    exp_q.push_back({1'b1, 1'b1, 8'h33});
    tog_en = 1'b1;
    send_byte(8'hA3, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    end_frame();
    wait_drain(n);
    tog_en = 1'b0;
    m_tready = 1'b1;
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL stall_drain: got left=%0d busy=%b, required 0 0",
               exp_q.size(), busy_o);
    end
  endtask

  task automatic test_same_cycle_end();
    int n;
    exp_q.push_back({1'b1, 1'b0, 8'h11});
    exp_q.push_back({1'b1, 1'b0, 8'h22});
    exp_q.push_back({1'b1, 1'b1, 8'h33});
    send_byte(8'hA3, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    wait_drain(n);
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL same_cycle_drain: got left=%0d, required 0", exp_q.size());
    end
    send_byte(8'h23, 1'b0);
    end_frame();
    @(posedge clock);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL hdr_only_busy: got %b, required 0", busy_o);
    end
    send_byte(8'h23, 1'b1);
    @(posedge clock);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL hdr_end_same_busy: got %b, required 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send_byte(8'h23, 1'b0);
    send_byte(8'h11, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, busy_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid: got v%b l%b u%b d%h r%b b%b, required all 0",
               m_tvalid, m_tlast, m_tuser, m_tdata, s_tready, busy_o);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    exp_q.push_back({1'b0, 1'b1, 8'h44});
    send_byte(8'h23, 1'b0);
    send_byte(8'h44, 1'b0);
    end_frame();
    wait_drain(n);
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL reset_mid_drain: got left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int c0;
    for (int i = 1; i <= 4; i++)
      exp_q.push_back({1'b1, (i == 4), 8'(i)});
    c0 = cyc;
    send_byte(8'hA3, 1'b0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    checks++;
    if (cyc - c0 != 5) begin
      errors++;
      $display("FAIL throughput: got %0d cycles, required 5", cyc - c0);
    end
    end_frame();
    wait_drain(n);
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL b2b_drain: got left=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hdr_err();
    test_len_err();
    test_stall();
    test_same_cycle_end();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
